// File: rtl/alu_cu_dmem.sv
// alu_cu_dmem: control decoder, combinational ALU and data memory for a small
// RV32I-style datapath.
// Optional feature macro: DMEM_BYTE_WRITE_EN. When defined, stores honour
// mem_wlen and touch only the addressed byte or halfword lanes. When undefined,
// every store writes the full 32-bit word.
module alu_cu_dmem #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  // decoder
  input  logic [16:0] cu_info,
  input  logic        nop_cu,
  output logic        we_reg,
  output logic        we_mem,
  output logic [2:0]  rf_sel,
  output logic [3:0]  alu_sel,
  output logic [1:0]  op2_sel,
  output logic        is_load,
  output logic        is_signed,
  output logic [1:0]  word_length,
  // ALU
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  alu_sel_ex,
  input  logic        is_signed_ex,
  output logic [31:0] alu_out,
  output logic        z,
  output logic        n,
  // data memory
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic [1:0]  mem_wlen,
  output logic [31:0] mem_rdata
);

  localparam int AW = $clog2(DMEM_WORDS);
  localparam logic [31:0] VIDEO_BASE = 32'h0000_8000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;      // funct7[5]: selects SUB / SRA
  logic       kill;     // bubble or reset squashes the side-effecting controls
  logic       unused_bits;

  assign opcode      = cu_info[6:0];
  assign funct3      = cu_info[9:7];
  assign alt         = cu_info[15];
  assign kill        = nop_cu | rst;
  assign unused_bits = ^{cu_info[16], cu_info[14:10]};

  // Shared funct3 -> ALU op map for R-type and I-type arithmetic.
  // For I-type, funct3=000 is always ADD since bit 30 is immediate data there.
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic sub_ok,
                                         input logic f7_alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (sub_ok && f7_alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7_alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Opcode decode with bubble/reset squashing applied in the same cycle.
  always_comb begin
    we_reg      = 1'b0;
    we_mem      = 1'b0;
    rf_sel      = 3'b000;
    alu_sel     = ALU_ADD;
    op2_sel     = 2'b00;
    is_load     = 1'b0;
    is_signed   = 1'b1;
    word_length = 2'b10;
    case (opcode)
      OP_R: begin
        we_reg    = 1'b1;
        op2_sel   = 2'b11;
        alu_sel   = alu_map(funct3, 1'b1, alt);
        is_signed = (funct3 != 3'b011);
      end
      OP_I: begin
        we_reg    = 1'b1;
        alu_sel   = alu_map(funct3, 1'b0, alt);
        is_signed = (funct3 != 3'b011);
      end
      OP_LOAD: begin
        we_reg      = 1'b1;
        rf_sel      = 3'b001;
        is_load     = 1'b1;
        word_length = funct3[1:0];
        is_signed   = ~funct3[2];
      end
      OP_STORE: begin
        we_mem      = 1'b1;
        op2_sel     = 2'b01;
        word_length = funct3[1:0];
      end
      OP_BRANCH: begin
        op2_sel   = 2'b11;
        alu_sel   = ALU_SUB;
        is_signed = ~funct3[1];
      end
      OP_JAL: begin
        we_reg  = 1'b1;
        rf_sel  = 3'b011;
        op2_sel = 2'b10;
      end
      OP_JALR: begin
        we_reg = 1'b1;
        rf_sel = 3'b011;
      end
      OP_LUI: begin
        we_reg = 1'b1;
        rf_sel = 3'b010;
      end
      OP_AUIPC: begin
        we_reg = 1'b1;
        rf_sel = 3'b100;
      end
      default: ;
    endcase
    if (kill) begin
      we_reg  = 1'b0;
      we_mem  = 1'b0;
      rf_sel  = 3'b000;
      alu_sel = ALU_ADD;
      op2_sel = 2'b00;
      is_load = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [4:0] shamt;
  logic       lt;

  assign shamt = op2[4:0];
  assign lt    = is_signed_ex ? ($signed(op1) < $signed(op2)) : (op1 < op2);
  assign z     = (alu_out == 32'd0);
  assign n     = lt;

  // Result mux; reserved codes produce zero.
  always_comb begin
    alu_out = 32'd0;
    case (alu_sel_ex)
      ALU_ADD: alu_out = op1 + op2;
      ALU_SUB: alu_out = op1 - op2;
      ALU_AND: alu_out = op1 & op2;
      ALU_OR:  alu_out = op1 | op2;
      ALU_XOR: alu_out = op1 ^ op2;
      ALU_SLL: alu_out = op1 << shamt;
      ALU_SRL: alu_out = op1 >> shamt;
      ALU_SRA: alu_out = $unsigned($signed(op1) >>> shamt);
      ALU_SLT: alu_out = {31'd0, lt};
      default: alu_out = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data memory: four byte-wide lanes, combinational read
  // ---------------------------------------------------------------------------
  logic [AW-1:0] mem_idx;
  logic          write_ok;
  logic [3:0]    lane_we;
  logic [31:0]   lane_wdata;

  assign mem_idx  = mem_addr[AW+1:2];
  assign write_ok = mem_we && !rst && (mem_addr < VIDEO_BASE);

`ifdef DMEM_BYTE_WRITE_EN
  // Lane enables and lane-replicated data for sub-word stores.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = mem_wdata;
    case (mem_wlen)
      2'b00: begin
        lane_we[mem_addr[1:0]] = 1'b1;
        lane_wdata             = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        lane_we    = mem_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{mem_wdata[15:0]}};
      end
      default: lane_we = 4'b1111;
    endcase
  end
`else
  logic unused_wlen;
  assign unused_wlen = ^mem_wlen;
  assign lane_we     = 4'b1111;
  assign lane_wdata  = mem_wdata;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DMEM_WORDS];

      // Lane write; contents survive reset.
      always_ff @(posedge clk) begin
        if (write_ok && lane_we[gi]) begin
          lane_mem[mem_idx] <= lane_wdata[gi*8 +: 8];
        end
      end

      assign mem_rdata[gi*8 +: 8] = lane_mem[mem_idx];
    end
  endgenerate

endmodule

// File: tb/tb_alu_cu_dmem.sv
// tb_alu_cu_dmem: directed vector tables for the ALU and decoder plus
// hand-written store sequences for the data memory.
module tb_alu_cu_dmem;

  logic        clk;
  logic        rst;
  logic [16:0] cu_info;
  logic        nop_cu;
  logic        we_reg, we_mem, is_load, is_signed;
  logic [2:0]  rf_sel;
  logic [3:0]  alu_sel;
  logic [1:0]  op2_sel, word_length;
  logic [31:0] op1, op2, alu_out;
  logic [3:0]  alu_sel_ex;
  logic        is_signed_ex, z, n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  mem_wlen;

  int checks = 0;
  int errors = 0;

  alu_cu_dmem #(.DMEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .cu_info(cu_info), .nop_cu(nop_cu),
    .we_reg(we_reg), .we_mem(we_mem), .rf_sel(rf_sel), .alu_sel(alu_sel),
    .op2_sel(op2_sel), .is_load(is_load), .is_signed(is_signed),
    .word_length(word_length),
    .op1(op1), .op2(op2), .alu_sel_ex(alu_sel_ex), .is_signed_ex(is_signed_ex),
    .alu_out(alu_out), .z(z), .n(n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_wlen(mem_wlen), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sel;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_z;
    logic        exp_n;
  } alu_vec_t;

  // exp packs {we_reg, we_mem, rf_sel, alu_sel, op2_sel, is_load, is_signed, word_length}
  typedef struct packed {
    logic [16:0] info;
    logic        nop;
    logic [14:0] exp;
  } dec_vec_t;

  alu_vec_t alu_tab [14];
  dec_vec_t dec_tab [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  function automatic logic [14:0] dec_bus();
    return {we_reg, we_mem, rf_sel, alu_sel, op2_sel, is_load, is_signed, word_length};
  endfunction

  // One clocked store; inputs are released 1 time unit after the edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] wlen);
    mem_addr  = addr;
    mem_wdata = data;
    mem_wlen  = wlen;
    mem_we    = 1'b1;
    @(posedge clk);
    #1;
    mem_we = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    mem_addr = addr;
    #1;
    chk(name, mem_rdata, exp);
  endtask

  initial begin
    // ALU table: sel, signed, op1, op2, result, z, n
    alu_tab[0]  = '{4'b0001, 1'b1, 32'd5,         32'd7,         32'hFFFFFFFE, 1'b0, 1'b1};
    alu_tab[1]  = '{4'b0000, 1'b1, 32'd5,         32'd7,         32'd12,       1'b0, 1'b1};
    alu_tab[2]  = '{4'b1000, 1'b1, 32'hFFFFFFFF,  32'd1,         32'd1,        1'b0, 1'b1};
    alu_tab[3]  = '{4'b1000, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,        1'b1, 1'b0};
    alu_tab[4]  = '{4'b0111, 1'b1, 32'h80000000,  32'd4,         32'hF8000000, 1'b0, 1'b1};
    alu_tab[5]  = '{4'b0110, 1'b1, 32'h80000000,  32'd4,         32'h08000000, 1'b0, 1'b1};
    alu_tab[6]  = '{4'b0010, 1'b0, 32'hF0F0F0F0,  32'h0FF00FF0,  32'h00F000F0, 1'b0, 1'b0};
    alu_tab[7]  = '{4'b0011, 1'b0, 32'hF0F0F0F0,  32'h0FF00FF0,  32'hFFF0FFF0, 1'b0, 1'b0};
    alu_tab[8]  = '{4'b0100, 1'b0, 32'hF0F0F0F0,  32'h0FF00FF0,  32'hFF00FF00, 1'b0, 1'b0};
    alu_tab[9]  = '{4'b0101, 1'b0, 32'd1,         32'd31,        32'h80000000, 1'b0, 1'b1};
    alu_tab[10] = '{4'b0000, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,        1'b1, 1'b0};
    alu_tab[11] = '{4'b1001, 1'b0, 32'd3,         32'd4,         32'd0,        1'b1, 1'b1};
    alu_tab[12] = '{4'b0001, 1'b1, 32'd9,         32'd9,         32'd0,        1'b1, 1'b0};
    alu_tab[13] = '{4'b0101, 1'b0, 32'd3,         32'h21,        32'd6,        1'b0, 1'b1};

    // Decoder table: {funct7, funct3, opcode}, nop, expected bus
    dec_tab[0]  = '{{7'b0100000, 3'b000, 7'b0110011}, 1'b0, {1'b1,1'b0,3'b000,4'b0001,2'b11,1'b0,1'b1,2'b10}};
    dec_tab[1]  = '{{7'b0000000, 3'b011, 7'b0110011}, 1'b0, {1'b1,1'b0,3'b000,4'b1000,2'b11,1'b0,1'b0,2'b10}};
    dec_tab[2]  = '{{7'b0100000, 3'b101, 7'b0110011}, 1'b0, {1'b1,1'b0,3'b000,4'b0111,2'b11,1'b0,1'b1,2'b10}};
    dec_tab[3]  = '{{7'b0000000, 3'b110, 7'b0110011}, 1'b0, {1'b1,1'b0,3'b000,4'b0011,2'b11,1'b0,1'b1,2'b10}};
    dec_tab[4]  = '{{7'b0100000, 3'b000, 7'b0010011}, 1'b0, {1'b1,1'b0,3'b000,4'b0000,2'b00,1'b0,1'b1,2'b10}};
    dec_tab[5]  = '{{7'b0100000, 3'b101, 7'b0010011}, 1'b0, {1'b1,1'b0,3'b000,4'b0111,2'b00,1'b0,1'b1,2'b10}};
    dec_tab[6]  = '{{7'b0000000, 3'b001, 7'b0010011}, 1'b0, {1'b1,1'b0,3'b000,4'b0101,2'b00,1'b0,1'b1,2'b10}};
    dec_tab[7]  = '{{7'b0000000, 3'b100, 7'b0000011}, 1'b1, {1'b0,1'b0,3'b000,4'b0000,2'b00,1'b0,1'b0,2'b00}};
    dec_tab[8]  = '{{7'b0000000, 3'b100, 7'b0000011}, 1'b0, {1'b1,1'b0,3'b001,4'b0000,2'b00,1'b1,1'b0,2'b00}};
    dec_tab[9]  = '{{7'b0000000, 3'b001, 7'b0000011}, 1'b0, {1'b1,1'b0,3'b001,4'b0000,2'b00,1'b1,1'b1,2'b01}};
    dec_tab[10] = '{{7'b0000000, 3'b010, 7'b0100011}, 1'b0, {1'b0,1'b1,3'b000,4'b0000,2'b01,1'b0,1'b1,2'b10}};
    dec_tab[11] = '{{7'b0000000, 3'b110, 7'b1100011}, 1'b0, {1'b0,1'b0,3'b000,4'b0001,2'b11,1'b0,1'b0,2'b10}};
    dec_tab[12] = '{{7'b0000000, 3'b100, 7'b1100011}, 1'b0, {1'b0,1'b0,3'b000,4'b0001,2'b11,1'b0,1'b1,2'b10}};
    dec_tab[13] = '{{7'b0000000, 3'b000, 7'b1101111}, 1'b0, {1'b1,1'b0,3'b011,4'b0000,2'b10,1'b0,1'b1,2'b10}};
    dec_tab[14] = '{{7'b0000000, 3'b000, 7'b1100111}, 1'b0, {1'b1,1'b0,3'b011,4'b0000,2'b00,1'b0,1'b1,2'b10}};
    dec_tab[15] = '{{7'b0000000, 3'b000, 7'b0110111}, 1'b0, {1'b1,1'b0,3'b010,4'b0000,2'b00,1'b0,1'b1,2'b10}};
    dec_tab[16] = '{{7'b0000000, 3'b000, 7'b0010111}, 1'b0, {1'b1,1'b0,3'b100,4'b0000,2'b00,1'b0,1'b1,2'b10}};

    rst          = 1'b1;
    cu_info      = {7'b0100000, 3'b000, 7'b0110011};
    nop_cu       = 1'b0;
    op1          = 32'd0;
    op2          = 32'd0;
    alu_sel_ex   = 4'd0;
    is_signed_ex = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    mem_we       = 1'b0;
    mem_wlen     = 2'b10;

    // Reset squashes controls even for a valid R-type instruction.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_controls", {20'd0, dec_bus()} >> 3, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rtype", {17'd0, dec_bus()}, {17'd0, 1'b1,1'b0,3'b000,4'b0001,2'b11,1'b0,1'b1,2'b10});

    // ALU vectors
    for (int i = 0; i < 14; i++) begin
      alu_sel_ex   = alu_tab[i].sel;
      is_signed_ex = alu_tab[i].sgn;
      op1          = alu_tab[i].a;
      op2          = alu_tab[i].b;
      #1;
      chk($sformatf("alu[%0d].out", i), alu_out, alu_tab[i].exp_out);
      chk($sformatf("alu[%0d].zn", i), {30'd0, z, n}, {30'd0, alu_tab[i].exp_z, alu_tab[i].exp_n});
    end

    // Decoder vectors
    for (int i = 0; i < 17; i++) begin
      cu_info = dec_tab[i].info;
      nop_cu  = dec_tab[i].nop;
      #1;
      chk($sformatf("dec[%0d]", i), {17'd0, dec_bus()}, {17'd0, dec_tab[i].exp});
    end
    nop_cu = 1'b0;
    // SYSTEM: side-effecting controls all zero
    cu_info = {7'b0000000, 3'b000, 7'b1110011};
    #1;
    chk("dec_system", {20'd0, dec_bus()} >> 3, 32'd0);

    // Memory: word store then read back
    @(posedge clk);
    #1;
    store(32'h0000_0000, 32'hA5A5A5A5, 2'b10);
    store(32'h0000_0010, 32'hDEADBEEF, 2'b10);
    read_chk("mem_word_0x10", 32'h10, 32'hDEADBEEF);
    read_chk("mem_word_0x0", 32'h0, 32'hA5A5A5A5);

    // Byte store into lane 1
    store(32'h0000_0011, 32'h00000055, 2'b00);
`ifdef DMEM_BYTE_WRITE_EN
    read_chk("mem_byte_0x11", 32'h10, 32'hDEAD55EF);
`else
    read_chk("mem_byte_0x11", 32'h10, 32'h00000055);
`endif

    // Half store into upper half
    store(32'h0000_0040, 32'h11223344, 2'b10);
    store(32'h0000_0042, 32'h0000ABCD, 2'b01);
`ifdef DMEM_BYTE_WRITE_EN
    read_chk("mem_half_0x42", 32'h40, 32'hABCD3344);
`else
    read_chk("mem_half_0x42", 32'h40, 32'h0000ABCD);
`endif

    // Video range store aliases index 0 but must not write
    store(32'h0000_8000, 32'h00001234, 2'b10);
    read_chk("mem_video_blocked", 32'h0, 32'hA5A5A5A5);

    // Store under reset must not write
    store(32'h0000_0020, 32'hCAFEF00D, 2'b10);
    rst = 1'b1;
    store(32'h0000_0020, 32'h00001234, 2'b10);
    rst = 1'b0;
    read_chk("mem_rst_blocked", 32'h20, 32'hCAFEF00D);

    // Same-cycle read/write: old data before the edge, new data after
    store(32'h0000_0030, 32'h11111111, 2'b10);
    mem_addr  = 32'h0000_0030;
    mem_wdata = 32'h22222222;
    mem_wlen  = 2'b10;
    mem_we    = 1'b1;
    #1;
    chk("mem_rw_before_edge", mem_rdata, 32'h11111111);
    @(posedge clk);
    #1;
    mem_we = 1'b0;
    chk("mem_rw_after_edge", mem_rdata, 32'h22222222);

    // Index wraps modulo depth: 0x1030 aliases 0x30
    read_chk("mem_wrap_alias", 32'h0000_1030, 32'h22222222);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
